// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer
//   Computes {CarryOut, SumOut} = InputA + InputB + InputCarry one nibble per
//   clock. A single 4-bit ripple-carry adder is reused. Nibble 0 is processed
//   first. For WIDTH=16 the result is ready 4 cycles after Start is accepted.
//
//   Optional build macro RCA_SEQ_SUBTRACT_EN:
//     Adds the Subtract input. When Subtract is 1 at Start, the block computes
//     InputA - InputB. In that case CarryOut = 1 means no borrow occurred.
//
// Ports
//   Clock       in   rising-edge clock
//   Reset       in   synchronous active-high reset
//   Start       in   begin one operation (sampled only in IDLE)
//   InputA      in   operand A, latched with Start
//   InputB      in   operand B, latched with Start
//   InputCarry  in   carry-in, latched with Start
//   Subtract    in   (RCA_SEQ_SUBTRACT_EN only) select A-B, latched with Start
//   Busy        out  high while nibbles are being processed
//   Done        out  one-cycle pulse when SumOut/CarryOut are valid
//   SumOut      out  result word, held until the next accepted Start
//   CarryOut    out  carry out of the MSB nibble, held likewise
//
// FSM states
//   state | meaning
//   IDLE  | waiting for Start
//   RUN   | processing nibble index, one per clock
//   DONE  | result valid, Done pulse

module ripple_carry_adder_rtl (
    input  logic [3:0] InputA,
    input  logic [3:0] InputB,
    input  logic       InputCarry,
    output logic [3:0] SumOut,
    output logic       CarryOut
);
    logic [4:0] chain;

    always_comb begin
        chain    = '0;
        SumOut   = '0;
        chain[0] = InputCarry;
        for (int i = 0; i < 4; i++) begin
            SumOut[i]    = InputA[i] ^ InputB[i] ^ chain[i];
            chain[i + 1] = (InputA[i] & InputB[i]) | (chain[i] & (InputA[i] ^ InputB[i]));
        end
        CarryOut = chain[4];
    end
endmodule

module rca_word_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             InputCarry,
`ifdef RCA_SEQ_SUBTRACT_EN
    input  logic             Subtract,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] SumOut,
    output logic             CarryOut
);
    localparam int N       = WIDTH / 4;
    localparam int INDEX_W = $clog2(N);
    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   operand_a;
    logic [WIDTH-1:0]   operand_b;
    logic               carry_reg;
    logic [INDEX_W-1:0] index;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry_out_reg;

    logic [3:0]         nibble_a;
    logic [3:0]         nibble_b;
    logic [3:0]         adder_sum;
    logic               adder_carry;

    // Subtraction is A + ~B + 1, so it only changes what gets latched.
    logic [WIDTH-1:0]   load_b;
    logic               load_carry;

    always_comb begin
`ifdef RCA_SEQ_SUBTRACT_EN
        load_b     = Subtract ? ~InputB : InputB;
        load_carry = Subtract ? 1'b1 : InputCarry;
`else
        load_b     = InputB;
        load_carry = InputCarry;
`endif
    end

    always_comb begin
        nibble_a = operand_a[{index, 2'b00} +: 4];
        nibble_b = operand_b[{index, 2'b00} +: 4];
    end

    ripple_carry_adder_rtl u_adder (
        .InputA     (nibble_a),
        .InputB     (nibble_b),
        .InputCarry (carry_reg),
        .SumOut     (adder_sum),
        .CarryOut   (adder_carry)
    );

    always_comb begin
        next_state = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) next_state = RUN;
            end
            RUN: begin
                Busy = 1'b1;
                if (index == LAST_INDEX) next_state = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            operand_a     <= '0;
            operand_b     <= '0;
            carry_reg     <= 1'b0;
            index         <= '0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (Start) begin
                        operand_a     <= InputA;
                        operand_b     <= load_b;
                        carry_reg     <= load_carry;
                        index         <= '0;
                        sum_reg       <= '0;
                        carry_out_reg <= 1'b0;
                    end
                end
                RUN: begin
                    sum_reg[{index, 2'b00} +: 4] <= adder_sum;
                    carry_reg                    <= adder_carry;
                    index                        <= index + 1'b1;
                    // CarryOut mirrors the carry register from DONE onward.
                    if (index == LAST_INDEX) carry_out_reg <= adder_carry;
                end
                default: ;
            endcase
        end
    end

    assign SumOut   = sum_reg;
    assign CarryOut = carry_out_reg;
endmodule
